// File: rtl/matrices_addsub_seq.sv
// matrices_addsub_seq: element-wise A+B / A-B over a batch of MATRICES_COUNT signed
// MATRIX_SIZE_M x MATRIX_SIZE_N matrices, walked by a LANES-wide datapath over
// ceil(E/LANES) beats, where E = MATRICES_COUNT*M*N.
//
// Optional build macro: MATRICES_ADDSUB_SAT_EN
//   defined   -> overflowing lanes clamp to the signed min/max
//   undefined -> overflowing lanes wrap modulo 2^DATA_WIDTH
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_calc_cmd       start request, only honoured while idle
//   i_op             0 = A+B, 1 = A-B, latched with the command
//   i_matrices_a/b   operand batches (element k at [k*DATA_WIDTH +: DATA_WIDTH])
//   o_matrices       registered result batch
//   o_busy           high while the batch is being processed
//   o_done           one-cycle pulse after the final beat
//   o_ready          result valid and block idle
//   o_overflow       sticky overflow flag for the current/last operation
module matrices_addsub_seq #(
  parameter int unsigned MATRICES_COUNT = 5,
  parameter int unsigned MATRIX_SIZE_M  = 4,
  parameter int unsigned MATRIX_SIZE_N  = 3,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned LANES          = 4
) (
  input  logic                                                            i_clk,
  input  logic                                                            i_rst_n,
  input  logic                                                            i_calc_cmd,
  input  logic                                                            i_op,
  input  logic [MATRICES_COUNT*MATRIX_SIZE_M*MATRIX_SIZE_N*DATA_WIDTH-1:0] i_matrices_a,
  input  logic [MATRICES_COUNT*MATRIX_SIZE_M*MATRIX_SIZE_N*DATA_WIDTH-1:0] i_matrices_b,
  output logic [MATRICES_COUNT*MATRIX_SIZE_M*MATRIX_SIZE_N*DATA_WIDTH-1:0] o_matrices,
  output logic                                                            o_busy,
  output logic                                                            o_done,
  output logic                                                            o_ready,
  output logic                                                            o_overflow
);

  localparam int unsigned E    = MATRICES_COUNT * MATRIX_SIZE_M * MATRIX_SIZE_N;
  localparam int unsigned DW   = DATA_WIDTH;
  // idx can step one full beat past E on the final beat
  localparam int unsigned IdxW = $clog2(E + LANES + 1);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                op_q, op_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                ovf_q, ovf_d;
  logic [E*DW-1:0]     res_q, res_d;

  logic [E*DW-1:0]     res_beat;
  logic                beat_ovf;
  logic                last_beat;

  // Datapath for one beat: lanes at or beyond E leave their (nonexistent) slot untouched.
  always_comb begin
    int unsigned     k;
    logic [DW-1:0]   a_el;
    logic [DW-1:0]   b_el;
    logic [DW:0]     a_ext;
    logic [DW:0]     b_ext;
    logic [DW:0]     sum;
    logic            lane_ovf;
    logic [DW-1:0]   val;
    res_beat = res_q;
    beat_ovf = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      k        = 32'(idx_q) + l;
      a_el     = '0;
      b_el     = '0;
      a_ext    = '0;
      b_ext    = '0;
      sum      = '0;
      lane_ovf = 1'b0;
      val      = '0;
      if (k < E) begin
        a_el     = i_matrices_a[k*DW +: DW];
        b_el     = i_matrices_b[k*DW +: DW];
        a_ext    = {a_el[DW-1], a_el};
        b_ext    = {b_el[DW-1], b_el};
        sum      = op_q ? (a_ext - b_ext) : (a_ext + b_ext);
        lane_ovf = sum[DW] ^ sum[DW-1];
`ifdef MATRICES_ADDSUB_SAT_EN
        // sum[DW] is the true sign of the unclipped result
        if (lane_ovf) begin
          val = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
          val = sum[DW-1:0];
        end
`else
        val = sum[DW-1:0];
`endif
        res_beat[k*DW +: DW] = val;
        beat_ovf             = beat_ovf | lane_ovf;
      end
    end
  end

  assign last_beat = (32'(idx_q) + LANES) >= E;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (i_calc_cmd) begin
          state_d = StCalc;
          op_d    = i_op;
          idx_d   = '0;
          ready_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      StCalc: begin
        res_d = res_beat;
        ovf_d = ovf_q | beat_ovf;
        idx_d = idx_q + IdxW'(LANES);
        if (last_beat) begin
          state_d = StIdle;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      op_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
    end
  end

  assign o_matrices = res_q;
  assign o_busy     = (state_q == StCalc);
  assign o_done     = done_q;
  assign o_ready    = ready_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_matrices_addsub_seq.sv
// Self-checking bench for matrices_addsub_seq: two instances (LANES=4 and LANES=7)
// share stimulus; a behavioural integer model predicts every output every cycle.
module tb_matrices_addsub_seq;

  localparam int unsigned E  = 60;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd, op;
  logic [E*DW-1:0] ma, mb;
  logic [E*DW-1:0] res4, res7;
  logic busy4, done4, ready4, ovf4;
  logic busy7, done7, ready7, ovf7;

  always #5 clk = ~clk;

  matrices_addsub_seq #(.LANES(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_calc_cmd(cmd), .i_op(op),
    .i_matrices_a(ma), .i_matrices_b(mb), .o_matrices(res4),
    .o_busy(busy4), .o_done(done4), .o_ready(ready4), .o_overflow(ovf4)
  );

  matrices_addsub_seq #(.LANES(7)) dut7 (
    .i_clk(clk), .i_rst_n(rst_n), .i_calc_cmd(cmd), .i_op(op),
    .i_matrices_a(ma), .i_matrices_b(mb), .o_matrices(res7),
    .o_busy(busy7), .o_done(done7), .o_ready(ready7), .o_overflow(ovf7)
  );

  int tests = 0;
  int fails = 0;
  int edge_no = 0;
  int t0 = 0;
  int first_done4, first_done7, done4_cnt;

  // Model state per instance (0: LANES=4, 1: LANES=7)
  int          lanes_of [2] = '{4, 7};
  int          m_pos    [2];
  bit          m_busy   [2];
  bit          m_done   [2];
  bit          m_ready  [2];
  bit          m_ovf    [2];
  bit          m_op     [2];
  logic [15:0] m_res    [2][E];

  function automatic logic [15:0] elem(input logic [E*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", nm, act, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_ready[i] = 0; m_ovf[i] = 0; m_op[i] = 0;
      for (int k = 0; k < E; k++) m_res[i][k] = 16'h0000;
    end
  endtask

  // One rising edge of behaviour, from the current (stable) inputs
  task automatic model_edge();
    int a, b, r;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pos[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_ready[i] = 0; m_ovf[i] = 0; m_op[i] = 0;
        for (int k = 0; k < E; k++) m_res[i][k] = 16'h0000;
      end else if (!m_busy[i]) begin
        m_done[i] = 0;
        if (cmd) begin
          m_busy[i] = 1; m_op[i] = op; m_pos[i] = 0; m_ready[i] = 0; m_ovf[i] = 0;
        end
      end else begin
        for (int k = m_pos[i]; k < m_pos[i] + lanes_of[i] && k < E; k++) begin
          a = $signed(elem(ma, k));
          b = $signed(elem(mb, k));
          r = m_op[i] ? a - b : a + b;
          if (r > 32767 || r < -32768) begin
            m_ovf[i] = 1;
`ifdef MATRICES_ADDSUB_SAT_EN
            r = (r > 0) ? 32767 : -32768;
`endif
          end
          m_res[i][k] = r[15:0];
        end
        m_pos[i] += lanes_of[i];
        if (m_pos[i] >= E) begin
          m_busy[i] = 0; m_done[i] = 1; m_ready[i] = 1;
        end else begin
          m_done[i] = 0;
        end
      end
    end
  endtask

  task automatic cmp_inst(input int i, input logic [E*DW-1:0] r,
                          input logic b, input logic d, input logic rd, input logic ov);
    int bad;
    bad = -1;
    chk($sformatf("busy%0d", lanes_of[i]), {31'd0, b}, {31'd0, m_busy[i]});
    chk($sformatf("done%0d", lanes_of[i]), {31'd0, d}, {31'd0, m_done[i]});
    chk($sformatf("ready%0d", lanes_of[i]), {31'd0, rd}, {31'd0, m_ready[i]});
    chk($sformatf("ovf%0d", lanes_of[i]), {31'd0, ov}, {31'd0, m_ovf[i]});
    for (int k = E - 1; k >= 0; k--) if (elem(r, k) !== m_res[i][k]) bad = k;
    if (bad < 0) chk($sformatf("res%0d", lanes_of[i]), 32'd0, 32'd0 + 0 * bad);
    else chk($sformatf("res%0d_e%0d", lanes_of[i], bad), {16'd0, elem(r, bad)},
             {16'd0, m_res[i][bad]});
  endtask

  task automatic compare_all();
    cmp_inst(0, res4, busy4, done4, ready4, ovf4);
    cmp_inst(1, res7, busy7, done7, ready7, ovf7);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    edge_no++;
    @(negedge clk);
    compare_all();
    if (done4) begin
      done4_cnt++;
      if (first_done4 < 0) first_done4 = edge_no;
    end
    if (done7 && first_done7 < 0) first_done7 = edge_no;
  endtask

  task automatic fill(input logic [15:0] av, input logic [15:0] bv);
    for (int k = 0; k < E; k++) begin
      ma[k*DW +: DW] = av;
      mb[k*DW +: DW] = bv;
    end
  endtask

  task automatic drain();
    cmd = 0;
    for (int i = 0; i < 60 && (busy4 || busy7); i++) tick();
    chk("drain", {30'd0, busy4, busy7}, 32'd0);
  endtask

  // Start a batch and check command-to-done latency on both instances
  task automatic run_batch(input logic opv, input bit rnd_cmd);
    cmd = 1; op = opv;
    t0 = edge_no + 1;
    first_done4 = -1; first_done7 = -1; done4_cnt = 0;
    tick();
    cmd = 0;
    for (int i = 0; i < 40 && (first_done4 < 0 || first_done7 < 0); i++) begin
      if (rnd_cmd) begin
        cmd = 1'($urandom_range(0, 1));
        op  = 1'($urandom_range(0, 1));
      end
      tick();
    end
    chk("lat4", first_done4 - t0, 32'd15);
    chk("lat7", first_done7 - t0, 32'd9);
    drain();
  endtask

  initial begin
    rst_n = 1; cmd = 0; op = 0; ma = '0; mb = '0;
    model_reset();
    #1 rst_n = 0;
    #2 compare_all();
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Add
    fill(16'h0003, 16'h0005);
    run_batch(1'b0, 1'b0);
    chk("add_e0", {16'd0, elem(res4, 0)}, 32'h0008);
    chk("add_e59", {16'd0, elem(res4, 59)}, 32'h0008);
    chk("add_ovf", {31'd0, ovf4}, 32'd0);
    chk("add_ready", {31'd0, ready4}, 32'd1);

    // Sub
    fill(16'h0002, 16'h0007);
    run_batch(1'b1, 1'b0);
    chk("sub_e5", {16'd0, elem(res4, 5)}, 32'hFFFB);
    chk("sub_ovf", {31'd0, ovf4}, 32'd0);

    // Positive overflow on element 17 (add)
    fill(16'h0000, 16'h0000);
    ma[17*DW +: DW] = 16'h7FFF; mb[17*DW +: DW] = 16'h0001;
    run_batch(1'b0, 1'b0);
`ifdef MATRICES_ADDSUB_SAT_EN
    chk("ovf_e17", {16'd0, elem(res4, 17)}, 32'h7FFF);
`else
    chk("ovf_e17", {16'd0, elem(res4, 17)}, 32'h8000);
`endif
    chk("ovf_flag_add", {31'd0, ovf4}, 32'd1);
    chk("ovf_e16", {16'd0, elem(res4, 16)}, 32'h0000);

    // Negative overflow on element 42 (sub)
    fill(16'h0000, 16'h0000);
    ma[42*DW +: DW] = 16'h8000; mb[42*DW +: DW] = 16'h0001;
    run_batch(1'b1, 1'b0);
`ifdef MATRICES_ADDSUB_SAT_EN
    chk("ovf_e42", {16'd0, elem(res7, 42)}, 32'h8000);
`else
    chk("ovf_e42", {16'd0, elem(res7, 42)}, 32'h7FFF);
`endif
    chk("ovf_flag_sub", {31'd0, ovf7}, 32'd1);
    chk("ovf_e17_clr", {16'd0, elem(res4, 17)}, 32'h0000);

    // Command re-pulsed while busy, including on the final beat's edge
    fill(16'h0003, 16'h0005);
    cmd = 1; op = 0; first_done4 = -1; first_done7 = -1; done4_cnt = 0;
    tick();
    for (int c = 1; c <= 20; c++) begin
      cmd = (c == 5 || c == 15);
      op  = cmd;
      tick();
    end
    chk("busy_cmd_done_cnt", done4_cnt, 32'd1);
    chk("busy_cmd_e0", {16'd0, elem(res4, 0)}, 32'h0008);
    chk("busy_cmd_idle", {31'd0, busy4}, 32'd0);
    drain();

    // Reset mid-batch
    fill(16'h1234, 16'h0101);
    cmd = 1; op = 0;
    tick();
    cmd = 0;
    repeat (7) tick();
    #2 rst_n = 0;
    model_reset();
    #1 compare_all();
    chk("rst_e0", {16'd0, elem(res4, 0)}, 32'h0000);
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    first_done4 = -1;
    repeat (2) tick();
    chk("rst_no_done", first_done4, 32'hFFFF_FFFF);
    rst_n = 1;
    run_batch(1'b0, 1'b0);
    chk("rst_after_e3", {16'd0, elem(res4, 3)}, 32'h1335);

    // Ramp operand, checked on the 7-lane instance
    for (int k = 0; k < E; k++) begin
      ma[k*DW +: DW] = 16'(k);
      mb[k*DW +: DW] = 16'h0100;
    end
    run_batch(1'b0, 1'b0);
    chk("l7_e0", {16'd0, elem(res7, 0)}, 32'h0100);
    chk("l7_e59", {16'd0, elem(res7, 59)}, 32'h013B);
    chk("l7_e56", {16'd0, elem(res7, 56)}, 32'h0138);

    // Randomized batches, some with stray commands while busy
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < E; k++) begin
        ma[k*DW +: DW] = 16'($urandom);
        mb[k*DW +: DW] = (n % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      end
      run_batch(1'($urandom_range(0, 1)), n >= 8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
